// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported 64-bit memory between the fetch port
// and the data port. Data wins over fetch, one access at a time, and a
// watchdog abandons an access the memory never acknowledges.
module mem_arbiter #(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic [1:0]    d_we,
  input  logic          d_dword,
  input  logic [N-1:0]  d_addr,
  input  logic [N-1:0]  d_wdata,
  output logic [N-1:0]  d_rdata,
  output logic          ready,
  output logic          mem_req,
  output logic [N-1:0]  mem_addr,
  output logic [1:0]    mem_we,
  output logic          mem_dword,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic          timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t          state_q;
  logic            i_done_q, d_done_q;
  logic            i_done_d, d_done_d;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q;
  logic [N-1:0]    mem_addr_q, mem_wdata_q;
  logic [1:0]      mem_we_q;
  logic            mem_dword_q;
  logic            i_sel_q;
  logic [31:0]     i_rdata_q;
  logic [N-1:0]    d_rdata_q;
  logic            terr_q;

  logic            busy, ack_d, ack_i, expire, fin_d, fin_i;
  logic            pend_d, pend_i, can_grant, grant_d, grant_i;

  assign ready       = (!i_req | i_done_q) & (!d_req | d_done_q);
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_dword   = mem_dword_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = terr_q;

  // Completion, watchdog expiry and arbitration; a finishing port is treated
  // as done so the other pending port can be granted with no bubble.
  always_comb begin
    busy      = (state_q != IDLE);
    ack_d     = (state_q == BUSY_D) & mem_ack;
    ack_i     = (state_q == BUSY_I) & mem_ack;
    expire    = busy & !mem_ack & (TIMEOUT != 0) & (cnt_q == TO_LAST);
    fin_d     = ack_d | (expire & (state_q == BUSY_D));
    fin_i     = ack_i | (expire & (state_q == BUSY_I));
    pend_d    = d_req & !(d_done_q | fin_d);
    pend_i    = i_req & !(i_done_q | fin_i);
    can_grant = (state_q == IDLE) | ack_d | ack_i;
    grant_d   = can_grant & pend_d;
    grant_i   = can_grant & pend_i & !pend_d;
    d_done_d  = ready ? 1'b0 : (d_done_q | fin_d);
    i_done_d  = ready ? 1'b0 : (i_done_q | fin_i);
  end

  // Arbiter FSM with registered memory-side fields and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 2'b00;
      mem_dword_q <= 1'b0;
      mem_wdata_q <= '0;
      i_sel_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      terr_q      <= 1'b0;
    end else begin
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      if (ack_i) i_rdata_q <= i_sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
      if (ack_d) d_rdata_q <= mem_rdata;
      if (expire) terr_q <= 1'b1;
      if (grant_d) begin
        state_q     <= BUSY_D;
        mem_req_q   <= 1'b1;
        mem_addr_q  <= d_addr;
        mem_we_q    <= d_we;
        mem_dword_q <= d_dword;
        mem_wdata_q <= d_wdata;
        cnt_q       <= '0;
      end else if (grant_i) begin
        state_q     <= BUSY_I;
        mem_req_q   <= 1'b1;
        mem_addr_q  <= {{(N-32){1'b0}}, i_addr};
        mem_we_q    <= 2'b00;
        mem_dword_q <= 1'b0;
        mem_wdata_q <= '0;
        i_sel_q     <= i_addr[2];
        cnt_q       <= '0;
      end else if (ack_d | ack_i | expire) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
        cnt_q     <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a default-timeout instance and a TIMEOUT=4
// instance share the same stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [1:0]  d_we;
  logic        d_dword;
  logic [63:0] d_addr, d_wdata, mem_rdata;
  logic        mem_ack;

  logic [31:0] i_rdata, t_i_rdata;
  logic [63:0] d_rdata, t_d_rdata;
  logic        ready, t_ready, mem_req, t_mem_req;
  logic [63:0] mem_addr, t_mem_addr, mem_wdata, t_mem_wdata;
  logic [1:0]  mem_we, t_mem_we;
  logic        mem_dword, t_mem_dword, timeout_err, t_timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_dword(d_dword), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .ready(ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_dword(mem_dword), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  mem_arbiter #(.N(64), .TIMEOUT(4)) u_to (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(t_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_dword(d_dword), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(t_d_rdata), .ready(t_ready),
    .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_we(t_mem_we),
    .mem_dword(t_mem_dword), .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .timeout_err(t_timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 2'b00; d_dword = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_mem_we", mem_we, 2'b00);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 64'h0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_ready", ready, 1'b1);
    reset = 1'b1;
    tick();

    // Fetch only, ack in the third memory cycle
    i_req = 1; i_addr = 32'h04; mem_rdata = 64'h11112222_33334444;
    #1;
    chk("f_ready_c0", ready, 1'b0);
    tick();
    chk("f_mem_req_c1", mem_req, 1'b1);
    chk("f_mem_addr", mem_addr, 64'h04);
    chk("f_mem_we", mem_we, 2'b00);
    chk("f_ready_c1", ready, 1'b0);
    tick();
    chk("f_ready_c2", ready, 1'b0);
    tick();
    chk("f_ready_c3", ready, 1'b0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("f_ready_c4", ready, 1'b1);
    chk("f_i_rdata", i_rdata, 32'h11112222);
    chk("f_mem_req_c4", mem_req, 1'b0);
    i_req = 0;
    tick();

    // Fetch and load together: data first, fetch granted with no gap
    i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 64'h80; d_we = 2'b00;
    #1;
    chk("fl_ready_c0", ready, 1'b0);
    tick();
    chk("fl_mem_req_c1", mem_req, 1'b1);
    chk("fl_mem_addr_d", mem_addr, 64'h80);
    mem_rdata = 64'hAAAABBBB_CCCCDDDD; mem_ack = 1;
    tick();
    chk("fl_mem_req_c2", mem_req, 1'b1);
    chk("fl_mem_addr_i", mem_addr, 64'h10);
    chk("fl_d_rdata", d_rdata, 64'hAAAABBBB_CCCCDDDD);
    chk("fl_ready_c2", ready, 1'b0);
    mem_rdata = 64'h55556666_77778888;
    tick();
    mem_ack = 0;
    chk("fl_ready_c3", ready, 1'b1);
    chk("fl_i_rdata", i_rdata, 32'h77778888);
    chk("fl_mem_req_c3", mem_req, 1'b0);
    chk("fl_d_rdata_hold", d_rdata, 64'hAAAABBBB_CCCCDDDD);
    i_req = 0; d_req = 0;
    tick();

    // Store: fields latched and held while the input address moves
    d_req = 1; d_we = 2'b01; d_dword = 1; d_addr = 64'h100;
    d_wdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    chk("st_mem_req", mem_req, 1'b1);
    chk("st_mem_addr", mem_addr, 64'h100);
    chk("st_mem_we", mem_we, 2'b01);
    chk("st_mem_dword", mem_dword, 1'b1);
    chk("st_mem_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
    for (int k = 0; k < 5; k++) begin
      d_addr = d_addr ^ 64'hFF0;
      tick();
      chk("st_hold_addr", mem_addr, 64'h100);
      chk("st_hold_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
      chk("st_hold_req", mem_req, 1'b1);
      chk("st_hold_we", mem_we, 2'b01);
    end
    mem_rdata = 64'h01234567_89ABCDEF; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("st_d_rdata", d_rdata, 64'h01234567_89ABCDEF);
    chk("st_ready", ready, 1'b1);
    chk("st_terr", timeout_err, 1'b0);
    d_req = 0; d_we = 2'b00; d_dword = 0; d_addr = '0; d_wdata = '0;
    tick();

    // Asynchronous reset during a fetch, then a stray ack
    i_req = 1; i_addr = 32'h08;
    tick();
    chk("ar_mem_req_busy", mem_req, 1'b1);
    #2;
    reset = 1'b0; i_req = 0;
    #1;
    chk("ar_mem_req_now", mem_req, 1'b0);
    tick();
    reset = 1'b1;
    mem_rdata = 64'hFFFFFFFF_FFFFFFFF; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("ar_i_rdata", i_rdata, 32'h0);
    chk("ar_mem_req", mem_req, 1'b0);
    chk("ar_ready", ready, 1'b1);
    tick();

    // Watchdog expiry on the TIMEOUT=4 instance
    i_req = 1; i_addr = 32'h20;
    tick();
    chk("to_mem_req_c1", t_mem_req, 1'b1);
    tick(); tick(); tick();
    chk("to_terr_c4", t_timeout_err, 1'b0);
    chk("to_mem_req_c4", t_mem_req, 1'b1);
    chk("to_ready_c4", t_ready, 1'b0);
    tick();
    chk("to_terr_c5", t_timeout_err, 1'b1);
    chk("to_mem_req_c5", t_mem_req, 1'b0);
    chk("to_ready_c5", t_ready, 1'b1);
    chk("to_i_rdata_keep", t_i_rdata, 32'h0);
    i_req = 0;
    tick();
    i_req = 1; i_addr = 32'h24;
    tick();
    chk("to_next_req", t_mem_req, 1'b1);
    chk("to_next_addr", t_mem_addr, 64'h24);
    mem_rdata = 64'h99990000_12345678; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("to_next_rdata", t_i_rdata, 32'h99990000);
    chk("to_next_ready", t_ready, 1'b1);
    chk("to_terr_sticky", t_timeout_err, 1'b1);
    i_req = 0;
    pulse_reset();
    chk("to_terr_cleared", t_timeout_err, 1'b0);

    // Ack arriving in the same cycle the watchdog would fire
    i_req = 1; i_addr = 32'h30;
    tick(); tick(); tick(); tick();
    chk("tie_mem_req_c4", t_mem_req, 1'b1);
    mem_rdata = 64'hABCDEF01_23456789; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("tie_terr", t_timeout_err, 1'b0);
    chk("tie_i_rdata", t_i_rdata, 32'h23456789);
    chk("tie_ready", t_ready, 1'b1);
    chk("tie_mem_req", t_mem_req, 1'b0);
    chk("tie_dut_i_rdata", i_rdata, 32'h23456789);
    i_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified 64-bit memory between the core's instruction-fetch port and data port.
- Serves at most one access at a time, with data taking priority over fetch.
- Drives the core's `ready` stall input: `ready` is high only once every asserted request has completed.
- Sits between the `mips` top-level ports and the external memory model; adds a watchdog for a memory that never acknowledges.

Parameters:
- N, 64, data width of the data port and memory bus.
- TIMEOUT, 255, cycles waiting for `mem_ack` before a transaction is abandoned; 0 disables the watchdog.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_req  input  1  instruction fetch request, held until `ready`.
- i_addr  input  32  fetch byte address.
- i_rdata  output  32  fetched instruction, registered.
- d_req  input  1  data access request (memread or memwrite), held until `ready`.
- d_we  input  2  write type, passed through to memory; 00 means read.
- d_dword  input  1  doubleword access, passed through.
- d_addr  input  N  data byte address.
- d_wdata  input  N  store data.
- d_rdata  output  N  load data, registered.
- ready  output  1  core may advance; low means stall.
- mem_req  output  1  memory transaction active.
- mem_addr  output  N  memory address.
- mem_we  output  2  memory write type.
- mem_dword  output  1  memory doubleword flag.
- mem_wdata  output  N  memory store data.
- mem_rdata  input  N  memory read data, valid with `mem_ack`.
- mem_ack  input  1  one-cycle completion from memory.
- timeout_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - state IDLE; i_done and d_done 0; timeout counter 0.
  - mem_req 0; mem_addr, mem_wdata, mem_we, mem_dword 0.
  - i_rdata 0; d_rdata 0; timeout_err 0.
  - Reset asserted mid-transaction drops it immediately; a late `mem_ack` arriving in IDLE is ignored.
- Ready: combinational, `ready = (!i_req | i_done) & (!d_req | d_done)`. With no requests, `ready` = 1.
- Done flags:
  - A flag is set on completion of its port's transaction.
  - Both flags clear in any cycle where `ready` = 1, so the core's next requests start fresh.
- States:
  - IDLE: pick a pending port (req=1 and done=0). D wins if both are pending; else I. Latch the memory fields into the mem_* registers, assert `mem_req` next cycle, go to BUSY_D or BUSY_I. If nothing is pending, stay.
  - BUSY_D / BUSY_I: hold `mem_req` and the latched fields stable until `mem_ack`. Requester input changes during BUSY are ignored.
  - On `mem_ack`: capture the result, set the port's done flag, then perform the IDLE arbitration in the same cycle. The other port, if still pending, is granted with zero bubble; otherwise deassert `mem_req` and go to IDLE.
- Field mapping:
  - Fetch: `mem_addr = {N-32 zeros, i_addr}`, `mem_we = 00`, `mem_dword = 0`, `mem_wdata = 0`.
  - Data: `d_addr`, `d_we`, `d_dword` and `d_wdata` pass through unchanged.
- Read data capture:
  - `i_rdata = i_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]`, using the latched address.
  - `d_rdata = mem_rdata` on a data ack, including writes. Each rdata register holds its value until its next ack.
- Latency: request in IDLE → `mem_req` at cycle +1 → with `mem_ack` at cycle k, `ready` rises at cycle k+1 if the other port is idle or done.
- Timeout:
  - The counter increments each BUSY cycle without `mem_ack`.
  - On reaching TIMEOUT: set `timeout_err`, mark the port done, deassert `mem_req`, and return to IDLE. The rdata register is left unchanged.
  - `mem_ack` and timeout in the same cycle: the ack wins.
  - The counter clears on every grant.

Test Plan:
- Reset, then fetch-only at i_addr=0x04 with mem_rdata=0x11112222_33334444 acked after 3 cycles → i_rdata=0x11112222, `ready` low for 4 cycles and then high, `mem_we`=00.
- Fetch and load (d_addr=0x80) raised together → D granted first; I granted in the D ack cycle with no idle gap; `ready` rises one cycle after the I ack; d_rdata and i_rdata both correct.
- Store d_we=01, d_dword=1, d_wdata=0xDEADBEEF_CAFEF00D → `mem_*` fields match exactly and stay stable over 5 wait cycles while d_addr is toggled on the input.
- Async reset pulsed while in BUSY_I → `mem_req`=0 immediately; a later `mem_ack` has no effect; `ready`=1 with no requests.
- TIMEOUT=4 with `mem_ack` never arriving → `timeout_err`=1 after 4 BUSY cycles, `ready` recovers, and the next fetch proceeds normally.
- `mem_ack` in the same cycle the timeout count is reached → no error flagged and data captured.
